// File: rtl/conn_arb_pkg.sv
// Shared types and constants for the connection-manager lookup arbiter.
package conn_arb_pkg;

  // Number of requesters sharing the lookup port (0 = TX path, 1 = RX/ingress path).
  localparam int NUM_REQ = 2;

  // Default response payload width used by the response field bundle.
  localparam int RESP_W_DEF = 32;

  // Requester index, also the tag stored per issued lookup.
  typedef logic [0:0] req_id_t;

  // Response fields returned by connection_manager for one lookup.
  typedef struct packed {
    logic                  hit;
    logic [RESP_W_DEF-1:0] data;
  } resp_fields_t;

endpackage

// File: rtl/conn_arb_tag_fifo.sv
// Tag FIFO: remembers which requester owns each in-flight lookup, in issue order.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module conn_arb_tag_fifo
  import conn_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  req_id_t     push_id,
  input  logic        pop,
  output req_id_t     head_id,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  req_id_t     mem_r [DEPTH];
  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  logic        do_push_s;
  logic        do_pop_s;

  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign count     = wr_ptr_r - rd_ptr_r;
  assign head_id   = mem_r[rd_ptr_r[AW-1:0]];
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  // Advance write/read pointers on accepted push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Store the owner tag of a newly issued lookup.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= push_id;
    end
  end

endmodule

// File: rtl/conn_lookup_arbiter.sv
// Round-robin arbiter sharing connection_manager's single lookup port between
// the TX path (requester 0) and the RX path (requester 1). Responses come back
// in order and are steered to the owner recorded in the tag FIFO.
// Optional macro CONN_ARB_STATS_EN adds grant and stall counters.
module conn_lookup_arbiter
  import conn_arb_pkg::*;
#(
  parameter int KEY_W     = 64,
  parameter int RESP_W    = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req0_valid,
  input  logic [KEY_W-1:0]             req0_key,
  output logic                         req0_ready,
  input  logic                         req1_valid,
  input  logic [KEY_W-1:0]             req1_key,
  output logic                         req1_ready,
  output logic                         resp0_valid,
  output logic                         resp0_hit,
  output logic [RESP_W-1:0]            resp0_data,
  input  logic                         resp0_ready,
  output logic                         resp1_valid,
  output logic                         resp1_hit,
  output logic [RESP_W-1:0]            resp1_data,
  input  logic                         resp1_ready,
  output logic                         cm_lookup_valid,
  output logic [KEY_W-1:0]             cm_lookup_key,
  input  logic                         cm_lookup_ready,
  input  logic                         cm_resp_valid,
  input  logic                         cm_resp_hit,
  input  logic [RESP_W-1:0]            cm_resp_data,
  output logic                         cm_resp_ready,
  output logic [$clog2(MAX_OUTST):0]   outstanding,
  output logic                         err_orphan
`ifdef CONN_ARB_STATS_EN
  ,
  output logic [31:0]                  grant_cnt0,
  output logic [31:0]                  grant_cnt1,
  output logic [31:0]                  stall_cnt
`endif
);

  localparam int CW = $clog2(MAX_OUTST) + 1;

  logic               out_valid_r;
  logic [KEY_W-1:0]   out_key_r;
  req_id_t            rr_last_r;
  logic               err_orphan_r;

  logic [NUM_REQ-1:0] req_valid_s;
  logic               handshake_s;
  logic               grant_ok_s;
  logic               grant_valid_s;
  req_id_t            grant_id_s;
  logic [KEY_W-1:0]   grant_key_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  req_id_t            head_id_s;
  logic [CW-1:0]      fifo_count_s;
  logic               pop_s;
  logic               orphan_s;

  assign req_valid_s = {req1_valid, req0_valid};
  assign handshake_s = out_valid_r & cm_lookup_ready;
  // Full FIFO means MAX_OUTST lookups are in flight; a same-cycle pop does not help.
  assign grant_ok_s  = (~out_valid_r | handshake_s) & ~fifo_full_s;

  // Round-robin pick; on contention the requester not granted last wins.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_id_s    = 1'b0;
    if (grant_ok_s) begin
      case (req_valid_s)
        2'b01: begin
          grant_valid_s = 1'b1;
          grant_id_s    = 1'b0;
        end
        2'b10: begin
          grant_valid_s = 1'b1;
          grant_id_s    = 1'b1;
        end
        2'b11: begin
          grant_valid_s = 1'b1;
          grant_id_s    = ~rr_last_r;
        end
        default: begin
          grant_valid_s = 1'b0;
          grant_id_s    = 1'b0;
        end
      endcase
    end else begin
      grant_valid_s = 1'b0;
      grant_id_s    = 1'b0;
    end
  end

  assign req0_ready  = grant_ok_s & (grant_id_s == 1'b0);
  assign req1_ready  = grant_ok_s & (grant_id_s == 1'b1);
  assign grant_key_s = (grant_id_s == 1'b1) ? req1_key : req0_key;

  // Steer the in-order response to the owner at the FIFO head; drop orphans.
  always_comb begin
    resp0_valid   = 1'b0;
    resp1_valid   = 1'b0;
    cm_resp_ready = 1'b1;
    orphan_s      = 1'b0;
    if (fifo_empty_s) begin
      cm_resp_ready = 1'b1;
      orphan_s      = cm_resp_valid;
    end else begin
      case (head_id_s)
        1'b0: begin
          resp0_valid   = cm_resp_valid;
          cm_resp_ready = resp0_ready;
        end
        1'b1: begin
          resp1_valid   = cm_resp_valid;
          cm_resp_ready = resp1_ready;
        end
        default: begin
          resp0_valid   = 1'b0;
          resp1_valid   = 1'b0;
          cm_resp_ready = 1'b1;
        end
      endcase
    end
  end

  assign resp0_hit  = cm_resp_hit;
  assign resp0_data = cm_resp_data;
  assign resp1_hit  = cm_resp_hit;
  assign resp1_data = cm_resp_data;
  assign pop_s      = cm_resp_valid & cm_resp_ready & ~fifo_empty_s;

  conn_arb_tag_fifo #(
    .DEPTH (MAX_OUTST)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (grant_valid_s),
    .push_id (grant_id_s),
    .pop     (pop_s),
    .head_id (head_id_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (fifo_count_s)
  );

  // Lookup output stage: load on grant, clear once connection_manager takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_key_r   <= '0;
    end else if (grant_valid_s) begin
      out_valid_r <= 1'b1;
      out_key_r   <= grant_key_s;
    end else if (handshake_s) begin
      out_valid_r <= 1'b0;
    end
  end

  // Remember the last granted requester; reset to 1 so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last_r <= 1'b1;
    end else if (grant_valid_s) begin
      rr_last_r <= grant_id_s;
    end
  end

  // Sticky flag for responses that arrive with nothing outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_orphan_r <= 1'b0;
    end else if (orphan_s) begin
      err_orphan_r <= 1'b1;
    end
  end

  assign cm_lookup_valid = out_valid_r;
  assign cm_lookup_key   = out_key_r;
  assign outstanding     = fifo_count_s;
  assign err_orphan      = err_orphan_r;

`ifdef CONN_ARB_STATS_EN
  logic [31:0] grant_cnt0_r;
  logic [31:0] grant_cnt1_r;
  logic [31:0] stall_cnt_r;

  // Per-requester grant counts and cycles where a request waited on grant_ok.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt0_r <= 32'd0;
      grant_cnt1_r <= 32'd0;
      stall_cnt_r  <= 32'd0;
    end else begin
      if (grant_valid_s && (grant_id_s == 1'b0)) begin
        grant_cnt0_r <= grant_cnt0_r + 32'd1;
      end
      if (grant_valid_s && (grant_id_s == 1'b1)) begin
        grant_cnt1_r <= grant_cnt1_r + 32'd1;
      end
      if ((req0_valid | req1_valid) & ~grant_ok_s) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end
    end
  end

  assign grant_cnt0 = grant_cnt0_r;
  assign grant_cnt1 = grant_cnt1_r;
  assign stall_cnt  = stall_cnt_r;
`endif

endmodule

// File: tb/tb_conn_lookup_arbiter.sv
// Directed self-checking bench for conn_lookup_arbiter.
module tb_conn_lookup_arbiter;

  localparam int KEY_W     = 64;
  localparam int RESP_W    = 32;
  localparam int MAX_OUTST = 4;
  localparam logic [KEY_W-1:0] KA = 64'h0000_0000_0000_AAAA;
  localparam logic [KEY_W-1:0] KB = 64'h0000_0000_0000_BBBB;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 req0_valid, req0_ready;
  logic [KEY_W-1:0]     req0_key;
  logic                 req1_valid, req1_ready;
  logic [KEY_W-1:0]     req1_key;
  logic                 resp0_valid, resp0_hit, resp0_ready;
  logic [RESP_W-1:0]    resp0_data;
  logic                 resp1_valid, resp1_hit, resp1_ready;
  logic [RESP_W-1:0]    resp1_data;
  logic                 cm_lookup_valid, cm_lookup_ready;
  logic [KEY_W-1:0]     cm_lookup_key;
  logic                 cm_resp_valid, cm_resp_hit, cm_resp_ready;
  logic [RESP_W-1:0]    cm_resp_data;
  logic [2:0]           outstanding;
  logic                 err_orphan;
`ifdef CONN_ARB_STATS_EN
  logic [31:0]          grant_cnt0, grant_cnt1, stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int g0 = 0;
  int g1 = 0;

  conn_lookup_arbiter #(
    .KEY_W     (KEY_W),
    .RESP_W    (RESP_W),
    .MAX_OUTST (MAX_OUTST)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req0_valid      (req0_valid),
    .req0_key        (req0_key),
    .req0_ready      (req0_ready),
    .req1_valid      (req1_valid),
    .req1_key        (req1_key),
    .req1_ready      (req1_ready),
    .resp0_valid     (resp0_valid),
    .resp0_hit       (resp0_hit),
    .resp0_data      (resp0_data),
    .resp0_ready     (resp0_ready),
    .resp1_valid     (resp1_valid),
    .resp1_hit       (resp1_hit),
    .resp1_data      (resp1_data),
    .resp1_ready     (resp1_ready),
    .cm_lookup_valid (cm_lookup_valid),
    .cm_lookup_key   (cm_lookup_key),
    .cm_lookup_ready (cm_lookup_ready),
    .cm_resp_valid   (cm_resp_valid),
    .cm_resp_hit     (cm_resp_hit),
    .cm_resp_data    (cm_resp_data),
    .cm_resp_ready   (cm_resp_ready),
    .outstanding     (outstanding),
    .err_orphan      (err_orphan)
`ifdef CONN_ARB_STATS_EN
    ,
    .grant_cnt0      (grant_cnt0),
    .grant_cnt1      (grant_cnt1),
    .stall_cnt       (stall_cnt)
`endif
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0; req0_key = '0;
    req1_valid = 1'b0; req1_key = '0;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    cm_lookup_ready = 1'b1;
    cm_resp_valid = 1'b0; cm_resp_hit = 1'b0; cm_resp_data = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // ---------------- reset state ----------------
    do_reset();
    #1;
    chk("rst_lookup_valid", cm_lookup_valid, 0);
    chk("rst_lookup_key",   cm_lookup_key, 0);
    chk("rst_outstanding",  outstanding, 0);
    chk("rst_err_orphan",   err_orphan, 0);

    // ---------------- 1: single lookup and response ----------------
    req0_valid = 1'b1; req0_key = 64'h1111;
    #1;
    chk("t1_req0_ready", req0_ready, 1);
    chk("t1_req1_ready", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("t1_lookup_valid", cm_lookup_valid, 1);
    chk("t1_lookup_key",   cm_lookup_key, 64'h1111);
    chk("t1_outst1",       outstanding, 1);
    tick();
    #1;
    chk("t1_lookup_drained", cm_lookup_valid, 0);
    cm_resp_valid = 1'b1; cm_resp_hit = 1'b1; cm_resp_data = 32'hABCD;
    #1;
    chk("t1_resp0_valid", resp0_valid, 1);
    chk("t1_resp0_hit",   resp0_hit, 1);
    chk("t1_resp0_data",  resp0_data, 32'hABCD);
    chk("t1_resp1_valid", resp1_valid, 0);
    chk("t1_cm_ready",    cm_resp_ready, 1);
    tick();
    cm_resp_valid = 1'b0;
    #1;
    chk("t1_outst0", outstanding, 0);

    // ---------------- 2: round-robin under contention ----------------
    do_reset();
    req0_valid = 1'b1; req0_key = KA;
    req1_valid = 1'b1; req1_key = KB;
    g0 = 0; g1 = 0;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("t2_ready0", req0_ready, (i % 2 == 0));
      chk("t2_ready1", req1_ready, (i % 2 == 1));
      if (i > 0) begin
        chk("t2_key",   cm_lookup_key, ((i - 1) % 2 == 0) ? KA : KB);
        chk("t2_route0", resp0_valid, ((i - 1) % 2 == 0));
        chk("t2_route1", resp1_valid, ((i - 1) % 2 == 1));
        chk("t2_outst",  outstanding, 1);
      end
      if (req0_valid && req0_ready) g0++;
      if (req1_valid && req1_ready) g1++;
      tick();
      cm_resp_valid = 1'b1; cm_resp_hit = 1'b0; cm_resp_data = i;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    chk("t2_last_route1", resp1_valid, 1);
    chk("t2_last_route0", resp0_valid, 0);
    tick();
    cm_resp_valid = 1'b0;
    #1;
    chk("t2_outst0",  outstanding, 0);
    chk("t2_grants0", g0, 8);
    chk("t2_grants1", g1, 8);
    chk("t2_no_orphan", err_orphan, 0);
`ifdef CONN_ARB_STATS_EN
    chk("t2_grant_cnt0", grant_cnt0, 8);
    chk("t2_grant_cnt1", grant_cnt1, 8);
    chk("t2_stall_cnt",  stall_cnt, 0);
`endif

    // ---------------- 3: outstanding limit ----------------
    do_reset();
    req0_valid = 1'b1; req0_key = KA;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t3_fill_ready", req0_ready, 1);
      tick();
    end
    #1;
    chk("t3_full_outst",  outstanding, 4);
    chk("t3_full_ready0", req0_ready, 0);
    chk("t3_full_ready1", req1_ready, 0);
    cm_resp_valid = 1'b1; cm_resp_data = 32'h5;
    #1;
    chk("t3_pop_resp0",     resp0_valid, 1);
    chk("t3_pop_no_grant",  req0_ready, 0);
    tick();
    cm_resp_valid = 1'b0;
    #1;
    chk("t3_after_pop_outst", outstanding, 3);
    chk("t3_after_pop_ready", req0_ready, 1);
    tick();
    #1;
    chk("t3_refull_outst", outstanding, 4);
    chk("t3_refull_ready", req0_ready, 0);
    tick();
    req0_valid = 1'b0;
    #1;
`ifdef CONN_ARB_STATS_EN
    chk("t3_stall_cnt",  stall_cnt, 2);
    chk("t3_grant_cnt0", grant_cnt0, 5);
`endif
    // reset while full must clear everything
    do_reset();
    #1;
    chk("t3_rst_outst", outstanding, 0);
    chk("t3_rst_valid", cm_lookup_valid, 0);
    chk("t3_rst_ready", req0_ready, 1);

    // ---------------- 4: in-order routing and backpressure ----------------
    req1_valid = 1'b1; req1_key = KB;
    #1;
    chk("t4_g1_ready", req1_ready, 1);
    tick();
    req1_valid = 1'b0; req0_valid = 1'b1; req0_key = KA;
    #1;
    chk("t4_g2_ready", req0_ready, 1);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b1;
    #1;
    chk("t4_g3_ready", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    #1;
    chk("t4_outst3", outstanding, 3);
    cm_resp_valid = 1'b1; cm_resp_hit = 1'b1; cm_resp_data = 32'd1;
    #1;
    chk("t4_r1_valid1", resp1_valid, 1);
    chk("t4_r1_data",   resp1_data, 1);
    chk("t4_r1_valid0", resp0_valid, 0);
    tick();
    cm_resp_data = 32'd2; resp0_ready = 1'b0;
    #1;
    chk("t4_r2_valid0",   resp0_valid, 1);
    chk("t4_r2_valid1",   resp1_valid, 0);
    chk("t4_r2_cm_ready", cm_resp_ready, 0);
    tick();
    #1;
    chk("t4_r2_held_outst", outstanding, 2);
    chk("t4_r2_held_ready", cm_resp_ready, 0);
    chk("t4_r2_data",       resp0_data, 2);
    resp0_ready = 1'b1;
    #1;
    chk("t4_r2_release", cm_resp_ready, 1);
    tick();
    cm_resp_data = 32'd3;
    #1;
    chk("t4_r3_valid1", resp1_valid, 1);
    chk("t4_r3_data",   resp1_data, 3);
    chk("t4_r3_valid0", resp0_valid, 0);
    tick();
    cm_resp_valid = 1'b0;
    #1;
    chk("t4_outst0",     outstanding, 0);
    chk("t4_no_orphan",  err_orphan, 0);

    // ---------------- 5: orphan response ----------------
    cm_resp_valid = 1'b1; cm_resp_data = 32'hDEAD;
    #1;
    chk("t5_cm_ready", cm_resp_ready, 1);
    chk("t5_valid0",   resp0_valid, 0);
    chk("t5_valid1",   resp1_valid, 0);
    tick();
    cm_resp_valid = 1'b0;
    #1;
    chk("t5_err_set", err_orphan, 1);
    tick();
    tick();
    chk("t5_err_sticky", err_orphan, 1);
    chk("t5_outst0",     outstanding, 0);
    do_reset();
    #1;
    chk("t5_err_cleared", err_orphan, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conn_lookup_arbiter.md
Name: conn_lookup_arbiter

Overview:
Shares the single forward-lookup port of connection_manager between two requesters: requester 0 is the TX path and requester 1 is the RX/ingress path. Arbitration is round-robin. A tag FIFO records which requester owns each issued lookup, and each in-order response is routed back to the owning requester. The block sits between the UDP TX/RX datapaths and connection_manager's s00/m00 lookup ports.

Parameters:
KEY_W, 64, lookup key width
RESP_W, 32, lookup response payload width
MAX_OUTST, 4, maximum lookups in flight; power of 2, minimum 2

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req0_valid  in  1  requester 0 lookup request valid
req0_key  in  KEY_W  requester 0 key
req0_ready  out  1  requester 0 request accepted
req1_valid  in  1  requester 1 lookup request valid
req1_key  in  KEY_W  requester 1 key
req1_ready  out  1  requester 1 request accepted
resp0_valid  out  1  response valid to requester 0
resp0_hit  out  1  hit flag to requester 0
resp0_data  out  RESP_W  response payload to requester 0
resp0_ready  in  1  requester 0 accepts response
resp1_valid, resp1_hit, resp1_data, resp1_ready  as above, for requester 1
cm_lookup_valid  out  1  to connection_manager s00 valid
cm_lookup_key  out  KEY_W  to connection_manager s00 key
cm_lookup_ready  in  1  from connection_manager s00 ready
cm_resp_valid  in  1  from connection_manager m00 valid
cm_resp_hit  in  1  from connection_manager m00 hit
cm_resp_data  in  RESP_W  from connection_manager m00 response
cm_resp_ready  out  1  to connection_manager m00 ready
outstanding  out  $clog2(MAX_OUTST)+1  lookups in flight, counting the output register
err_orphan  out  1  sticky flag: a response arrived with no lookup outstanding

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values: cm_lookup_valid=0, key register=0, tag FIFO empty, outstanding=0, err_orphan=0, rr_last=1 (so requester 0 wins first).
- Request output register:
  - cm_lookup_valid/cm_lookup_key come from a single register stage.
  - The register holds its value until cm_lookup_ready is seen with cm_lookup_valid.
- Grant condition (grant_ok): (output register empty, OR it is handshaking this cycle) AND outstanding < MAX_OUTST.
- Arbitration is combinational, evaluated when grant_ok is true:
  - Only one requester valid: that requester is granted.
  - Both valid: grant the requester that is not rr_last.
  - rr_last updates to the granted index.
- reqN_ready = grant_ok AND granted==N. The ready may depend on reqN_valid.
- Grant effects: the key loads into the output register on the next edge, and the granted index is pushed into the tag FIFO on the same edge.
- Latency: 1 cycle from the request handshake to cm_lookup_valid.
- Throughput: 1 lookup per cycle when cm_lookup_ready is held high.
- Response routing (combinational from the FIFO head):
  - resp[head]_valid = cm_resp_valid, with hit and data passed through.
  - The other requester's resp_valid is 0.
  - cm_resp_ready = resp[head]_ready.
- The FIFO pops on a cm_resp handshake.
- Orphan response (FIFO empty while cm_resp_valid=1): cm_resp_ready=1 so the beat is dropped, both resp_valid outputs are 0, and err_orphan sets and stays set until reset.
- outstanding:
  - +1 on grant; −1 on response pop.
  - A grant and a pop in the same cycle leave it unchanged.
  - It never exceeds MAX_OUTST.
- At full (outstanding==MAX_OUTST), both readies are 0. A pop in the same cycle does not enable a grant in that cycle; the grant occurs the next cycle.
- FIFO pointers wrap modulo MAX_OUTST and use an extra bit to distinguish full from empty.
- Reset mid-operation clears all state immediately. In-flight connection_manager responses arriving after reset are orphans; it is the integrator's duty to reset connection_manager at the same time.

Optional Feature:
CONN_ARB_STATS_EN:
- Defined: adds outputs grant_cnt0 and grant_cnt1 (32 bits each, wrap on overflow, reset 0), each incrementing on its requester's grant. Also adds stall_cnt (32 bits), incrementing each cycle that some reqN_valid=1 while grant_ok=0.
- Undefined: these ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package conn_arb_pkg holds the requester index typedef (req_id_t, 1 bit), the NUM_REQ=2 constant, and the struct {hit, data} used for response fields.
- Sub-module conn_arb_tag_fifo: a synchronous FIFO of req_id_t, MAX_OUTST deep, providing push/pop/full/empty/count.

Test Plan:
1. After reset, pulse req0_valid with key 0x1111 while cm_lookup_ready=1 → cm_lookup_valid=1 and key=0x1111 on the next cycle. Then a response hit=1, data=0xABCD → appears on resp0 only; outstanding returns 0.
2. Hold req0 and req1 valid continuously with cm_lookup_ready=1 → grants alternate 0,1,0,1, first grant to 0. Each requester gets 50% over 16 cycles.
3. Hold cm_resp_valid=0 and issue 4 lookups → outstanding=4 and both readies=0. Return one response → exactly one new grant on the following cycle.
4. Issue the order req1, req0, req1, then return responses data 1,2,3 → routed to resp1, resp0, resp1 respectively. With resp0_ready=0 on the second response, cm_resp_ready=0 until resp0_ready rises.
5. Drive cm_resp_valid=1 with the FIFO empty → cm_resp_ready=1, no resp valid asserted, err_orphan=1, which persists until rst.
6. With CONN_ARB_STATS_EN: scenario 2 for 16 cycles → grant_cnt0=8, grant_cnt1=8. Scenario 3's full period increments stall_cnt.
